// File: rtl/gmem_port_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gmem_port_scheduler_pkg                                          |
// | Brief   : Cluster-wide constants and helpers for the global-memory port.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gmem_port_scheduler_pkg;

  localparam int CORE_ID_WIDTH = 4;

  // Address split shared with the cluster top: MSB selects device space.
  localparam logic [31:0] GMEM_GLOBAL_BASE = 32'h0000_0000;
  localparam logic [31:0] GMEM_DEVICE_BASE = 32'h8000_0000;

  typedef enum logic [0:0] {
    SCHED_RR  = 1'b0,
    SCHED_TDM = 1'b1
  } sched_mode_e;

`ifdef GMEM_SCHED_STATIC_EN
  localparam sched_mode_e SCHED_MODE = SCHED_TDM;
`else
  localparam sched_mode_e SCHED_MODE = SCHED_RR;
`endif

  // True when two or more bits of the vector are set.
  function automatic logic f_multi_hot(input logic [15:0] vec);
    return (vec & (vec - 16'd1)) != 16'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gmem_port_scheduler_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gmem_port_scheduler_rr_pick                                      |
// | Brief   : Combinational find-first-set starting just above last_ptr.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gmem_port_scheduler_rr_pick #(
  parameter int NUM_CORES = 8,
  parameter int PTR_W     = 3
) (
  input  logic [NUM_CORES-1:0] request,
  input  logic [PTR_W-1:0]     last_ptr,
  output logic [NUM_CORES-1:0] winner_oh,
  output logic [PTR_W-1:0]     winner_id
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // NUM_CORES is a power of two, so truncating the sum wraps the search;
  // the previous owner is visited last.
  always_comb begin
    winner_oh = '0;
    winner_id = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      w_idx = PTR_W'(int'(last_ptr) + k);
      if (!w_found && request[w_idx]) begin
        w_found          = 1'b1;
        winner_oh[w_idx] = 1'b1;
        winner_id        = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gmem_port_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gmem_port_scheduler                                              |
// | Brief   : Round-robin global-memory port arbiter with bounded lock hold.   |
// |           Define GMEM_SCHED_STATIC_EN for fixed TDM rotation instead.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gmem_port_scheduler
  import gmem_port_scheduler_pkg::*;
#(
  parameter int NUM_CORES = 8,
  parameter int MAX_HOLD  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CORES-1:0]     request,
  input  logic [NUM_CORES-1:0]     lock,
  output logic [NUM_CORES-1:0]     grant_oh,
  output logic [CORE_ID_WIDTH-1:0] grant_id,
  output logic                     grant_valid,
  output logic [CNT_WIDTH-1:0]     contention_cnt
);

  localparam int PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] c_hold_max = HOLD_W'(MAX_HOLD - 1);

  logic [NUM_CORES-1:0] r_grant_oh;
  logic [PTR_W-1:0]     r_grant_id;
  logic                 r_grant_valid;
  logic [CNT_WIDTH-1:0] r_contention_cnt;
  logic                 w_contend;

  assign grant_oh       = r_grant_oh;
  assign grant_id       = CORE_ID_WIDTH'(r_grant_id);
  assign grant_valid    = r_grant_valid;
  assign contention_cnt = r_contention_cnt;

  assign w_contend = f_multi_hot(16'(request));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_contention_cnt <= '0;
    end else if (w_contend && (r_contention_cnt != '1)) begin
      r_contention_cnt <= r_contention_cnt + 1'b1;
    end
  end

`ifdef GMEM_SCHED_STATIC_EN

  logic [PTR_W-1:0] w_next_id;
  logic             w_unused_lock;

  assign w_next_id     = r_grant_id + 1'b1;
  assign w_unused_lock = ^lock;

  // Fixed slot rotation; valid only reflects whether the slot owner is asking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant_oh    <= NUM_CORES'(1);
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      r_grant_oh    <= {r_grant_oh[NUM_CORES-2:0], r_grant_oh[NUM_CORES-1]};
      r_grant_id    <= w_next_id;
      r_grant_valid <= request[w_next_id];
    end
  end

`else

  logic [PTR_W-1:0]     r_last_ptr;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [NUM_CORES-1:0] w_winner_oh;
  logic [PTR_W-1:0]     w_winner_id;
  logic                 w_owner_lock;
  logic                 w_hold_ok;

  gmem_port_scheduler_rr_pick #(
    .NUM_CORES (NUM_CORES),
    .PTR_W     (PTR_W)
  ) u_rr_pick (
    .request   (request),
    .last_ptr  (r_last_ptr),
    .winner_oh (w_winner_oh),
    .winner_id (w_winner_id)
  );

  assign w_owner_lock = |(request & lock & r_grant_oh);
  assign w_hold_ok    = w_owner_lock && (r_hold_cnt < c_hold_max);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant_oh    <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_last_ptr    <= PTR_W'(NUM_CORES - 1);
      r_hold_cnt    <= '0;
    end else if (w_hold_ok) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end else if (|request) begin
      r_grant_oh    <= w_winner_oh;
      r_grant_id    <= w_winner_id;
      r_grant_valid <= 1'b1;
      r_last_ptr    <= w_winner_id;
      // A saturated locking owner that wins again (nobody else asked) stays saturated.
      if (!(w_owner_lock && (w_winner_oh == r_grant_oh))) begin
        r_hold_cnt <= '0;
      end
    end else begin
      r_grant_oh    <= '0;
      r_grant_valid <= 1'b0;
      r_hold_cnt    <= '0;
    end
  end

`endif

  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(r_grant_oh));

endmodule
`default_nettype wire

// File: tb/tb_gmem_port_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_gmem_port_scheduler                                           |
// | Brief   : Directed self-checking bench; TDM vectors under                  |
// |           GMEM_SCHED_STATIC_EN, round-robin vectors otherwise.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gmem_port_scheduler;

  logic        clk;
  logic        reset;
  logic [7:0]  request;
  logic [7:0]  lock;
  logic [7:0]  grant_oh;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic [15:0] contention_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  gmem_port_scheduler #(
    .NUM_CORES (8),
    .MAX_HOLD  (4),
    .CNT_WIDTH (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .request        (request),
    .lock           (lock),
    .grant_oh       (grant_oh),
    .grant_id       (grant_id),
    .grant_valid    (grant_valid),
    .contention_cnt (contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset   = 1'b0;
    request = 8'h00;
    lock    = 8'h00;
    tick();
    reset   = 1'b1;
  endtask

  initial begin
    int exp3 [10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
    logic [7:0] oh;

    reset   = 1'b0;
    request = 8'h00;
    lock    = 8'h00;
    tick();
    tick();

`ifdef GMEM_SCHED_STATIC_EN
    chk("tdm_reset_oh", grant_oh, 8'h01);
    chk("tdm_reset_cnt", contention_cnt, 16'd0);
    reset   = 1'b1;
    request = 8'h10;
    for (int i = 1; i <= 16; i++) begin
      tick();
      oh = 8'h01 << (i % 8);
      chk("tdm_oh", grant_oh, oh);
      chk("tdm_id", grant_id, i % 8);
      chk("tdm_valid", grant_valid, (i % 8) == 4);
    end
    chk("tdm_cnt", contention_cnt, 16'd0);
`else
    chk("reset_oh", grant_oh, 8'h00);
    chk("reset_valid", grant_valid, 1'b0);
    chk("reset_id", grant_id, 4'd0);
    chk("reset_cnt", contention_cnt, 16'd0);

    // All cores requesting: strict rotation from core 0.
    reset   = 1'b1;
    request = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      tick();
      oh = 8'h01 << (i % 8);
      chk("rr_id", grant_id, i % 8);
      chk("rr_oh", grant_oh, oh);
      chk("rr_valid", grant_valid, 1'b1);
    end
    chk("rr_cnt", contention_cnt, 16'd16);

    // Core 0 locks against core 2: four cycles, forced rotate, back to core 0.
    pulse_reset();
    request = 8'h05;
    lock    = 8'h01;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_id", grant_id, exp3[i]);
    end
    chk("hold_cnt", contention_cnt, 16'd10);

    // Sole requester keeps the port indefinitely under lock.
    pulse_reset();
    request = 8'h01;
    lock    = 8'h01;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("solo_oh", grant_oh, 8'h01);
    end
    chk("solo_cnt", contention_cnt, 16'd0);

    // Reset mid-lock clears the grant at once.
    pulse_reset();
    request = 8'h08;
    lock    = 8'h08;
    tick();
    chk("lock3_id", grant_id, 4'd3);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_oh", grant_oh, 8'h00);
    chk("midrst_valid", grant_valid, 1'b0);
    reset = 1'b1;
    lock  = 8'h00;
    tick();
    chk("post_rst_id", grant_id, 4'd3);
    chk("post_rst_oh", grant_oh, 8'h08);

    // Idle: grant drops, id holds.
    request = 8'h00;
    tick();
    chk("idle_oh", grant_oh, 8'h00);
    chk("idle_valid", grant_valid, 1'b0);
    chk("idle_id", grant_id, 4'd3);

    // Lock from a non-owner is ignored: core 1 owns, core 2 locks.
    request = 8'h02;
    tick();
    chk("nonown_a", grant_id, 4'd1);
    request = 8'h06;
    lock    = 8'h04;
    tick();
    chk("nonown_b", grant_id, 4'd2);
    request = 8'h02;
    lock    = 8'h00;
    tick();
    chk("nonown_c", grant_id, 4'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
